// File: rtl/board_serializer.sv
// Streams a solved board to a UART transmitter: m, n, then each active row packed LSB-first.
// Define SERIALIZER_CHECKSUM_EN to append an XOR checksum byte after the last row byte.
module board_serializer #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]    solution,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   m,
    input  logic [$clog2(MAX_COLS+1)-1:0]   n,
    input  logic                            transmit_done,
    output logic                            send,
    output logic [7:0]                      byte_out,
    output logic                            busy,
    output logic                            done,
    output logic                            dim_error
);

    localparam int MW      = $clog2(MAX_ROWS+1);
    localparam int NW      = $clog2(MAX_COLS+1);
    localparam int CELLS   = MAX_ROWS*MAX_COLS;
    localparam int BPR_MAX = (MAX_COLS+7)/8;
    localparam int KW      = (BPR_MAX > 1) ? $clog2(BPR_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;
    typedef enum logic [1:0] {ST_M, ST_N, ST_ROWS, ST_CSUM} stage_t;

    state_t             state_q;
    stage_t             stage_q, stage_d;
    logic [CELLS-1:0]   sol_q;
    logic [MW-1:0]      m_q;
    logic [NW-1:0]      n_q;
    logic [MW-1:0]      row_q, row_d;
    logic [KW-1:0]      k_q, k_d;
    logic [7:0]         byte_q, byte_d;
    logic               send_q, busy_q, done_q, dim_error_q;
    logic               last_d;
    int                 bpr;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    // Gathers columns 8k..8k+7 of one row; columns at or beyond the active width read as 0.
    function automatic logic [7:0] rowByte(input logic [CELLS-1:0] sol, input int row,
                                           input int k, input int cols);
        logic [7:0]       b;
        logic [CELLS-1:0] shifted;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            int col;
            col = 8*k + i;
            if (col < cols && col < MAX_COLS && row < MAX_ROWS) begin
                shifted = sol >> (row*MAX_COLS + col);
                b[i]    = shifted[0];
            end
        end
        return b;
    endfunction

    always_comb begin
        bpr     = (int'(n_q) + 7) / 8;
        stage_d = stage_q;
        row_d   = row_q;
        k_d     = k_q;
        byte_d  = byte_q;
        last_d  = 1'b0;
        case (stage_q)
            ST_M: begin
                stage_d = ST_N;
                byte_d  = 8'(n_q);
            end
            ST_N: begin
                stage_d = ST_ROWS;
                row_d   = '0;
                k_d     = '0;
                byte_d  = rowByte(sol_q, 0, 0, int'(n_q));
            end
            ST_ROWS: begin
                if (int'(k_q) + 1 < bpr) begin
                    k_d    = KW'(int'(k_q) + 1);
                    byte_d = rowByte(sol_q, int'(row_q), int'(k_q) + 1, int'(n_q));
                end else if (int'(row_q) + 1 < int'(m_q)) begin
                    row_d  = MW'(int'(row_q) + 1);
                    k_d    = '0;
                    byte_d = rowByte(sol_q, int'(row_q) + 1, 0, int'(n_q));
                end else begin
`ifdef SERIALIZER_CHECKSUM_EN
                    stage_d = ST_CSUM;
                    byte_d  = csum_q;
`else
                    last_d  = 1'b1;
`endif
                end
            end
            default: last_d = 1'b1;
        endcase
    end

    // Outputs are registered so send, done and dim_error are clean one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= ST_M;
            sol_q       <= '0;
            m_q         <= '0;
            n_q         <= '0;
            row_q       <= '0;
            k_q         <= '0;
            byte_q      <= '0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dim_error_q <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            dim_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (m != '0 && int'(m) <= MAX_ROWS && n != '0 && int'(n) <= MAX_COLS) begin
                            sol_q   <= solution;
                            m_q     <= m;
                            n_q     <= n;
                            row_q   <= '0;
                            k_q     <= '0;
                            stage_q <= ST_M;
                            byte_q  <= 8'(m);
                            send_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= SEND;
`ifdef SERIALIZER_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end else begin
                            dim_error_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    send_q  <= 1'b0;
                    state_q <= WAIT;
`ifdef SERIALIZER_CHECKSUM_EN
                    csum_q  <= csum_q ^ byte_q;
`endif
                end
                WAIT: begin
                    if (transmit_done) begin
                        stage_q <= stage_d;
                        row_q   <= row_d;
                        k_q     <= k_d;
                        if (last_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FINISH;
                        end else begin
                            byte_q  <= byte_d;
                            send_q  <= 1'b1;
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign send      = send_q;
    assign byte_out  = byte_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dim_error = dim_error_q;

endmodule

// File: tb/tb_board_serializer.sv
// Directed bench for board_serializer: a UART stand-in answers each send two cycles later.
module tb_board_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic [120:0] solution;
    logic [3:0]   m;
    logic [3:0]   n;
    logic         transmit_done;
    logic         send;
    logic [7:0]   byte_out;
    logic         busy;
    logic         done;
    logic         dim_error;

    int           checks = 0;
    int           passes = 0;

    logic [7:0]   got[$];
    logic [7:0]   expq[$];
    int           doneCnt;
    int           firstAt;
    bit           gapBad, stableBad, busyBad;

    board_serializer #(.MAX_ROWS(11), .MAX_COLS(11)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .solution(solution),
        .m(m), .n(n), .transmit_done(transmit_done), .send(send),
        .byte_out(byte_out), .busy(busy), .done(done), .dim_error(dim_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one valid_in pulse starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [3:0] mm, input logic [3:0] nn, input logic [120:0] sol);
        m        = mm;
        n        = nn;
        solution = sol;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Plays the transmitter, recording every byte; optionally injects ignored events or stops early.
    task automatic serveStream(input int abortAt, input bit inject);
        int         cd;
        int         lastSend;
        int         doneAt;
        logic [7:0] held;
        got.delete();
        doneCnt   = 0;
        firstAt   = -1;
        gapBad    = 0;
        stableBad = 0;
        busyBad   = 0;
        cd        = 0;
        lastSend  = -100;
        doneAt    = -1;
        held      = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            transmit_done = 1'b0;
            valid_in      = 1'b0;
            if (send) begin
                if (got.size() != 0 && cyc - lastSend != 3) gapBad = 1;
                if (got.size() == 0) firstAt = cyc;
                got.push_back(byte_out);
                held     = byte_out;
                lastSend = cyc;
                cd       = 2;
                if (!busy) busyBad = 1;
                if (abortAt == got.size()) return;
                if (inject && got.size() == 3) transmit_done = 1'b1;
            end else if (cd > 0) begin
                if (byte_out !== held) stableBad = 1;
                cd--;
                if (inject && got.size() == 3 && cd == 1) begin
                    valid_in = 1'b1;
                    m        = 4'd2;
                    n        = 4'd2;
                    solution = '1;
                end
                if (cd == 0) transmit_done = 1'b1;
            end
            if (done) begin
                doneCnt++;
                doneAt = cyc;
                if (busy) busyBad = 1;
            end
            if (doneAt >= 0 && cyc >= doneAt + 3) break;
            @(negedge clk);
        end
        transmit_done = 1'b0;
        valid_in      = 1'b0;
    endtask

    task automatic checkStream(input string tag, input logic [7:0] e[$]);
        checkOutput({tag, " count"}, got.size(), e.size());
        foreach (e[i])
            checkOutput($sformatf("%s byte%0d", tag, i),
                        (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(e[i]));
        checkOutput({tag, " done pulses"}, doneCnt, 1);
        checkOutput({tag, " first send cycle"}, firstAt, 0);
        checkOutput({tag, " gap/stable/busy flags"}, {gapBad, stableBad, busyBad}, 0);
    endtask

    initial begin
        bit badFlag;
        rst_n         = 1'b1;
        valid_in      = 1'b0;
        transmit_done = 1'b0;
        solution      = '0;
        m             = '0;
        n             = '0;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset outputs", {send, byte_out, busy, done, dim_error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 11x11 all ones");
        applyStimulus(4'd11, 4'd11, '1);
        serveStream(0, 0);
        expq = {8'h0B, 8'h0B};
        repeat (11) begin
            expq.push_back(8'hFF);
            expq.push_back(8'h07);
        end
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'hF8);
`endif
        checkStream("full", expq);

        $display("[TB] 3x5 single cell");
        applyStimulus(4'd3, 4'd5, 121'(1) << 15);
        serveStream(0, 0);
        expq = {8'h03, 8'h05, 8'h00, 8'h10, 8'h00};
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'h16);
`endif
        checkStream("3x5", expq);

        $display("[TB] 2x9 all ones, two bytes per row");
        applyStimulus(4'd2, 4'd9, '1);
        serveStream(0, 0);
        expq = {8'h02, 8'h09, 8'hFF, 8'h01, 8'hFF, 8'h01};
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'h0B);
`endif
        checkStream("2x9", expq);

        $display("[TB] 1x1 smallest board");
        applyStimulus(4'd1, 4'd1, 121'(1));
        serveStream(0, 0);
        expq = {8'h01, 8'h01, 8'h01};
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'h01);
`endif
        checkStream("1x1", expq);

        $display("[TB] rejected dimensions");
        applyStimulus(4'd12, 4'd5, '1);
        checkOutput("m=12 dim_error/busy/send", {dim_error, busy, send}, 3'b100);
        @(negedge clk);
        checkOutput("m=12 pulse ends", {dim_error, busy, send}, 3'b000);
        applyStimulus(4'd4, 4'd0, '1);
        checkOutput("n=0 dim_error/busy/send", {dim_error, busy, send}, 3'b100);
        @(negedge clk);
        checkOutput("n=0 pulse ends", {dim_error, busy, send}, 3'b000);

        $display("[TB] ignored valid_in and transmit_done");
        applyStimulus(4'd3, 4'd5, 121'(1) << 15);
        serveStream(0, 1);
        expq = {8'h03, 8'h05, 8'h00, 8'h10, 8'h00};
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'h16);
`endif
        checkStream("inject", expq);

        $display("[TB] reset mid-stream");
        applyStimulus(4'd11, 4'd11, '1);
        serveStream(5, 0);
        checkOutput("abort 5th byte", got.size() == 5 ? 32'(got[4]) : 32'hDEAD, 8'hFF);
        rst_n = 1'b0;
        #1 checkOutput("abort outputs", {send, byte_out, busy, done, dim_error}, 0);
        badFlag = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || send || busy) badFlag = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || send || busy) badFlag = 1;
        end
        checkOutput("abort stays idle", badFlag, 0);
        applyStimulus(4'd3, 4'd5, 121'(1) << 15);
        serveStream(0, 0);
        expq = {8'h03, 8'h05, 8'h00, 8'h10, 8'h00};
`ifdef SERIALIZER_CHECKSUM_EN
        expq.push_back(8'h16);
`endif
        checkStream("restart", expq);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
